// File: rtl/fpu_pkg.sv
// Shared widths, opcodes and request bundle for the fpu issue path.
package fpu_pkg;

    localparam int FP_W = 32;
    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_MUL = 2'b10;
    localparam logic [OP_W-1:0] OP_DIV = 2'b11;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic [OP_W-1:0] op;
    } fpu_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers.
// A pop frees the slot for a push at the same edge, even when full.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign count   = wptr - rptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fpu_dispatch.sv
// Issue stage for a fixed-latency fpu: request queue, credit-gated
// issue, latency-tracking capture into an in-order response queue.
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int FPU_LAT   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [FP_W-1:0]              req_a,
    input  logic [FP_W-1:0]              req_b,
    input  logic [OP_W-1:0]              req_op,
    output logic [FP_W-1:0]              fpu_a,
    output logic [FP_W-1:0]              fpu_b,
    output logic [OP_W-1:0]              fpu_opcode,
    input  logic [FP_W-1:0]              fpu_o,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [FP_W-1:0]              rsp_data,
    output logic [$clog2(FPU_LAT+1)-1:0] inflight,
    output logic                         idle
);

    localparam int IW  = $clog2(FPU_LAT + 1);
    localparam int RQW = $clog2(REQ_DEPTH) + 1;
    localparam int RSW = $clog2(RSP_DEPTH) + 1;
    localparam int CW  = $clog2(RSP_DEPTH + FPU_LAT + 1) + 1;

    fpu_req_t         req_in;
    fpu_req_t         req_head;
    logic             req_full;
    logic             req_empty;
    logic [RQW-1:0]   req_count;
    logic             rsp_full;
    logic             rsp_empty;
    logic [RSW-1:0]   rsp_count;
    logic [FPU_LAT-1:0] sr;
    logic [CW-1:0]    used;
    logic             issue;
    logic             capture;

    assign req_in    = '{a: req_a, b: req_b, op: req_op};
    assign req_ready = !req_full;
    assign rsp_valid = !rsp_empty;

    // Slots already promised: queued results plus ops still in the fpu.
    assign used    = CW'(rsp_count) + CW'(inflight);
    assign issue   = !req_empty && (used < CW'(RSP_DEPTH));
    assign capture = sr[FPU_LAT-1];

    assign idle = (req_count == '0) && (rsp_count == '0) &&
                  (inflight == '0);

    sync_fifo #(
        .WIDTH ($bits(fpu_req_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && req_ready),
        .wdata (req_in),
        .pop   (issue),
        .rdata (req_head),
        .full  (req_full),
        .empty (req_empty),
        .count (req_count)
    );

    sync_fifo #(
        .WIDTH (FP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .wdata (fpu_o),
        .pop   (rsp_ready),
        .rdata (rsp_data),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_a      <= '0;
            fpu_b      <= '0;
            fpu_opcode <= '0;
            sr         <= '0;
            inflight   <= '0;
        end else begin
            if (issue) begin
                fpu_a      <= req_head.a;
                fpu_b      <= req_head.b;
                fpu_opcode <= req_head.op;
            end
            sr <= (sr << 1) | FPU_LAT'(issue);
            if (issue && !capture)
                inflight <= inflight + IW'(1);
            else if (!issue && capture)
                inflight <= inflight - IW'(1);
        end
    end

    a_rsp_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        capture |-> (!rsp_full || (rsp_ready && rsp_valid))
    );

endmodule
